// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;
    localparam int BIT_CNT_W  = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversampling-edge and bit-position counters for one received frame.
module uart_edge_bit_counter #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  edge_bit_en,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count
);

    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);

    logic [PRESCALE_W-1:0] last_edge;
    logic                  at_wrap;

    // An illegal Prescale of 0 makes last_edge 63, so the count still wraps modulo 64.
    assign last_edge = Prescale - EDGE_ONE;
    assign at_wrap   = (edge_count == last_edge);

    // Dropping the enable clears both counters and takes priority over a wrap.
    always_ff @(posedge CLK) begin
        if (RST || !edge_bit_en) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (at_wrap) begin
            edge_count <= '0;
            bit_count  <= bit_count + BIT_ONE;
        end else begin
            edge_count <= edge_count + EDGE_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX timing stage: edge/bit counters plus a three-sample majority vote
// taken around the centre of each bit.
module uart_rx_sampler #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S_DATA,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  edge_bit_en,
    input  logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    import uart_rx_pkg::*;

    localparam int FRAME_BITS = DATA_WIDTH + 3;
    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);

    // The bit counter must be able to index every bit of the longest frame.
    if (FRAME_BITS > (1 << BIT_CNT_W)) begin : g_frame_too_long
        $error("uart_rx_sampler: bit_count too narrow for DATA_WIDTH");
    end

    logic [PRESCALE_W-1:0] half_point;
    logic [PRESCALE_W-1:0] pt_first;
    logic [PRESCALE_W-1:0] pt_mid;
    logic [PRESCALE_W-1:0] pt_last;

    logic s0;
    logic s1;
    logic s2;
    logic s0_next;
    logic s1_next;
    logic s2_next;
    logic vote_strobe;

    uart_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_counter (
        .CLK         (CLK),
        .RST         (RST),
        .Prescale    (Prescale),
        .edge_bit_en (edge_bit_en),
        .edge_count  (edge_count),
        .bit_count   (bit_count)
    );

    assign half_point = Prescale >> 1;
    assign pt_first   = half_point - EDGE_ONE;
    assign pt_mid     = half_point;
    assign pt_last    = half_point + EDGE_ONE;

    // Next sample window; the last capture point also triggers the vote.
    always_comb begin
        s0_next     = s0;
        s1_next     = s1;
        s2_next     = s2;
        vote_strobe = 1'b0;
        if (dat_samp_en) begin
            if (edge_count == pt_first) begin
                s0_next = S_DATA;
            end
            if (edge_count == pt_mid) begin
                s1_next = S_DATA;
            end
            if (edge_count == pt_last) begin
                s2_next     = S_DATA;
                vote_strobe = 1'b1;
            end
        end
    end

    // Samples and the voted bit rest at the idle line level after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            s2           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            s0           <= s0_next;
            s1           <= s1_next;
            s2           <= s2_next;
            sample_valid <= vote_strobe;
            if (vote_strobe) begin
                sampled_bit <= majority3(s0_next, s1_next, s2_next);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: a cycle-count model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_rx_sampler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       S_DATA;
    logic [5:0] Prescale;
    logic       edge_bit_en;
    logic       dat_samp_en;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       sample_valid;

    int assert_count = 0;
    int fail_count   = 0;
    bit check_en     = 1'b0;

    // Model: enabled cycles since the last clear, the three window samples, and outputs.
    int m_cycles  = 0;
    bit m_samp[3] = '{1'b1, 1'b1, 1'b1};
    bit m_sampled = 1'b1;
    bit m_valid   = 1'b0;

    uart_rx_sampler #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6),
        .BIT_CNT_W  (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .S_DATA       (S_DATA),
        .Prescale     (Prescale),
        .edge_bit_en  (edge_bit_en),
        .dat_samp_en  (dat_samp_en),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assert_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit samp, input bit d);
        @(negedge CLK);
        RST         = rst;
        edge_bit_en = en;
        dat_samp_en = samp;
        S_DATA      = d;
        @(posedge CLK);
        #1;
    endtask

    // Model update: position in bit = cycles mod Prescale, window at half-1..half+1.
    always @(posedge CLK) begin
        int p;
        int cur;
        int k;
        int ones;
        p   = int'(Prescale);
        cur = m_cycles % p;
        if (RST) begin
            m_cycles  = 0;
            m_samp    = '{1'b1, 1'b1, 1'b1};
            m_sampled = 1'b1;
            m_valid   = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (dat_samp_en) begin
                k = cur - (p / 2 - 1);
                if (k >= 0 && k <= 2) begin
                    m_samp[k] = S_DATA;
                    if (k == 2) begin
                        ones      = int'(m_samp[0]) + int'(m_samp[1]) + int'(m_samp[2]);
                        m_sampled = (ones >= 2);
                        m_valid   = 1'b1;
                    end
                end
            end
            m_cycles = edge_bit_en ? m_cycles + 1 : 0;
        end
    end

    always @(negedge CLK) begin
        int p;
        if (check_en) begin
            p = int'(Prescale);
            checkOutput("edge_count", int'(edge_count), m_cycles % p);
            checkOutput("bit_count", int'(bit_count), (m_cycles / p) % 16);
            checkOutput("sampled_bit", int'(sampled_bit), int'(m_sampled));
            checkOutput("sample_valid", int'(sample_valid), int'(m_valid));
        end
    end

    initial begin
        bit d;
        RST         = 1'b1;
        edge_bit_en = 1'b0;
        dat_samp_en = 1'b0;
        S_DATA      = 1'b1;
        Prescale    = 6'd8;

        // Reset held two cycles with the enable high and the line low
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check_en = 1'b1;
        checkOutput("reset edge_count", int'(edge_count), 0);
        checkOutput("reset bit_count", int'(bit_count), 0);
        checkOutput("reset sampled_bit", int'(sampled_bit), 1);
        checkOutput("reset sample_valid", int'(sample_valid), 0);

        // Counter wrap at Prescale 8
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 8) begin
                checkOutput("wrap1 edge_count", int'(edge_count), 0);
                checkOutput("wrap1 bit_count", int'(bit_count), 1);
            end
            if (i == 16) begin
                checkOutput("wrap2 bit_count", int'(bit_count), 2);
            end
        end
        checkOutput("wrap end edge_count", int'(edge_count), 4);
        checkOutput("wrap end bit_count", int'(bit_count), 2);
        checkOutput("model cycle count", m_cycles, 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear edge_count", int'(edge_count), 0);

        // Vote at Prescale 8: samples 0,1,0 at edges 3,4,5
        for (int i = 0; i < 8; i++) begin
            d = (i == 3 || i == 5) ? 1'b0 : 1'b1;
            applyStimulus(1'b0, 1'b1, 1'b1, d);
            if (i == 5) begin
                checkOutput("vote8 sampled_bit", int'(sampled_bit), 0);
                checkOutput("vote8 sample_valid", int'(sample_valid), 1);
                checkOutput("vote8 edge_count", int'(edge_count), 6);
            end
            if (i == 6) begin
                checkOutput("vote8 strobe width", int'(sample_valid), 0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Glitch rejection at Prescale 16: 1,0,0 then 1,1,0
        Prescale = 6'd16;
        for (int i = 0; i < 32; i++) begin
            int e;
            int b;
            e = i % 16;
            b = i / 16;
            d = (b == 0) ? !(e == 8 || e == 9) : !(e == 9);
            applyStimulus(1'b0, 1'b1, 1'b1, d);
            if (i == 9) begin
                checkOutput("glitch0 sampled_bit", int'(sampled_bit), 0);
                checkOutput("glitch0 sample_valid", int'(sample_valid), 1);
                checkOutput("glitch0 bit_count", int'(bit_count), 0);
            end
            if (i == 25) begin
                checkOutput("glitch1 sampled_bit", int'(sampled_bit), 1);
                checkOutput("glitch1 bit_count", int'(bit_count), 1);
                checkOutput("glitch1 edge_count", int'(edge_count), 10);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Enable drop at edge 5, Prescale 32: centre point 17 never reached
        Prescale = 6'd32;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("drop pre edge_count", int'(edge_count), 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop edge_count", int'(edge_count), 0);
        checkOutput("drop bit_count", int'(bit_count), 0);
        checkOutput("drop sample_valid", int'(sample_valid), 0);
        checkOutput("drop sampled_bit", int'(sampled_bit), 1);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-frame reset at bit 4, edge 10, Prescale 16
        Prescale = 6'd16;
        for (int i = 0; i < 74; i++) begin
            d = ((i / 16) % 2) == 1;
            applyStimulus(1'b0, 1'b1, 1'b1, d);
        end
        checkOutput("midframe edge_count", int'(edge_count), 10);
        checkOutput("midframe bit_count", int'(bit_count), 4);
        checkOutput("midframe sampled_bit", int'(sampled_bit), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("abort edge_count", int'(edge_count), 0);
        checkOutput("abort bit_count", int'(bit_count), 0);
        checkOutput("abort sampled_bit", int'(sampled_bit), 1);
        checkOutput("abort sample_valid", int'(sample_valid), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("restart edge_count", int'(edge_count), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Receive-side timing and sampling stage for the UART RX path. It sits directly upstream of the RX control FSM. It counts oversampling edges and bit positions within a frame, and takes three samples of the serial line around each bit centre. The majority-voted bit goes to the FSM's start, parity and stop checkers and to the deserializer. The FSM drives `edge_bit_en` and `dat_samp_en`; this block returns `edge_count`, `bit_count` and `sampled_bit`.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame. Max frame length is start + data + parity + stop, which is 11 for 8 bits.
- `PRESCALE_W`, default 6: width of `Prescale` and `edge_count`.
- `BIT_CNT_W`, default 4: width of `bit_count`.

Ports:
- `CLK` in 1: oversampling clock. One clock; all state updates on the rising edge.
- `RST` in 1: reset is synchronous and active-high.
- `S_DATA` in 1: serial line, already synchronized to `CLK` upstream.
- `Prescale` in 6: oversampling ratio. Legal values are 8, 16 and 32.
- `edge_bit_en` in 1: counter enable from the FSM.
- `dat_samp_en` in 1: sampling enable from the FSM.
- `edge_count` out 6: cycle index within the current bit, 0..Prescale-1.
- `bit_count` out 4: bit index within the frame. 0 is the start bit.
- `sampled_bit` out 1: majority-voted value of the current bit.
- `sample_valid` out 1: one-cycle strobe; `sampled_bit` was updated this cycle.

## Operation
**Counters**
- `edge_bit_en`=1: `edge_count` increments each cycle.
- When `edge_count` == Prescale-1: `edge_count` goes to 0 and `bit_count` increments.
- `edge_bit_en`=0: both counters are cleared to 0 on the next edge.
- A clear caused by `edge_bit_en`=0 wins over a simultaneous wrap.
- `bit_count` wraps 15→0. It never saturates; the FSM leaves the frame before bit 11.
- `edge_count`=0 corresponds to the first cycle of a bit. For the start bit, that is the first cycle the FSM sees `S_DATA` low in IDLE.

**Sampling**
- Sample points, all computed in 6 bits:
  - H = Prescale>>1
  - first sample at H-1
  - second sample at H
  - third sample at H+1
- With `dat_samp_en`=1, `S_DATA` is captured into s0, s1 and s2 when `edge_count` equals H-1, H and H+1 respectively.
- On the edge that captures s2:
  - `sampled_bit` <= majority(s0, s1, `S_DATA`)
  - `sample_valid` <= 1 for exactly one cycle
- `dat_samp_en`=0: no captures and no strobe. s0..s2 and `sampled_bit` hold their values.
- Prescale=0 or Prescale<4 is illegal. Outputs are then undefined, but the block must not lock up: the counters still wrap via the Prescale-1 compare, or keep running modulo 64.

**Reset**
- When `RST`=1 at an edge:
  - `edge_count`=0, `bit_count`=0
  - `sampled_bit`=1 (idle line level)
  - `sample_valid`=0
  - s0..s2 = 1
- `RST` asserted mid-frame aborts immediately; all state takes its reset value on the next edge.

## Timing
- Counter outputs are registered, with 1-cycle enable-to-count latency.
- `sampled_bit` is valid from `edge_count` = H+2 onward. This is before the FSM's Prescale-1 decision point for every legal Prescale; for 8, valid at 6 and decision at 7.
- `sample_valid` is high in the cycle where `edge_count` = H+2.
- Once a frame has started, `Prescale` must not change. If it does, the compares use the new value immediately and no recovery is promised.
- No combinational path from any input to any output.

## Structure
- Package `uart_rx_pkg` holds:
  - the PRESCALE_W and BIT_CNT_W constants
  - the legal-prescale constants PRESCALE_8, PRESCALE_16 and PRESCALE_32
  - function `majority3`
- Sub-module `uart_edge_bit_counter` holds the edge/bit counters and is instantiated once.
- The sampler logic (sample-point compares, s0..s2, vote) lives in the top level.

## Test plan
- **Reset:** hold `RST`=1 for 2 cycles with `edge_bit_en`=1 and `S_DATA`=0 → `edge_count`=0, `bit_count`=0, `sampled_bit`=1, `sample_valid`=0.
- **Counter wrap:** Prescale=8, `edge_bit_en` held for 20 cycles → `edge_count` sequence 0..7,0..7,0..3; `bit_count` steps to 1 and 2 on the wrap edges; after 20 cycles `bit_count`=2 and `edge_count`=4.
- **Vote, Prescale=8:** `S_DATA` = 0,1,0 at `edge_count` 3, 4, 5 → `sampled_bit`=0 and a single `sample_valid` pulse at `edge_count`=6.
- **Glitch rejection, Prescale=16:** samples 1,0,0 at `edge_count` 7, 8, 9 → `sampled_bit`=0. Samples 1,1,0 in the next bit → `sampled_bit`=1, with `bit_count`=1.
- **Enable drop:** deassert `edge_bit_en` and `dat_samp_en` at `edge_count`=5, Prescale=32 → both counters 0 next cycle; no `sample_valid` (point 17 never reached); `sampled_bit` unchanged.
- **Mid-frame reset:** assert `RST` at `bit_count`=4, `edge_count`=10, Prescale=16 → all outputs at reset values next cycle. After release, `edge_count` restarts from 0.
